// File: rtl/uart_cmd_ctrl_pkg.sv
// uart_cmd_ctrl_pkg
//   Shared definitions for the UART command controller: FSM state
//   encodings, reply bytes, command-byte field positions and small helpers.
package uart_cmd_ctrl_pkg;

  // Reply bytes
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  // Command byte fields: [7] write, [6:4] reserved (must be 0), [3:0] address
  localparam int CMD_WR_BIT  = 7;
  localparam int CMD_RSV_HI  = 6;
  localparam int CMD_RSV_LO  = 4;
  localparam int CMD_ADDR_HI = 3;
  localparam int CMD_ADDR_LO = 0;

  // Frame-level controller; the byte transmit handshake lives in uart_tx_hs
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GET_DATA,
    ST_EXEC,
    ST_TX
  } ctrl_state_t;

  // Per-byte transmit handshake
  typedef enum logic [1:0] {
    HS_IDLE,
    HS_TX_LOAD,
    HS_TX_WAIT_HI,
    HS_TX_WAIT_LO
  } hs_state_t;

  function automatic logic cmd_is_legal(input logic [7:0] cmd, input int num_regs);
    return (cmd[CMD_RSV_HI:CMD_RSV_LO] == 3'b000) &&
           (int'(cmd[CMD_ADDR_HI:CMD_ADDR_LO]) < num_regs);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_tx_hs.sv
// uart_tx_hs
//   Sends one byte to the UART transmitter per start pulse. tx_transmit is
//   held until the UART reports busy, then dropped, and done pulses once the
//   UART goes idle again, so the request line is always low between bytes.
// Ports
//   clk, rst_n   system clock, async active-low reset
//   start        begin sending 'data' (accepted only when idle)
//   data         byte to send, sampled in TX_LOAD
//   done         one-cycle pulse after the UART has finished the byte
//   tx_transmit  request to the UART transmitter
//   tx_byte      byte presented to the UART, stable while tx_transmit=1
//   tx_busy      UART is_transmitting
//
// state          | meaning
// ---------------+-------------------------------------------------------
// HS_IDLE        | waiting for start
// HS_TX_LOAD     | capture data, raise tx_transmit
// HS_TX_WAIT_HI  | hold tx_transmit until the UART reports busy
// HS_TX_WAIT_LO  | request released, wait for the UART to finish
module uart_tx_hs
  import uart_cmd_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       done,
  output logic       tx_transmit,
  output logic [7:0] tx_byte,
  input  logic       tx_busy
);

  hs_state_t state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HS_IDLE;
      done        <= 1'b0;
      tx_transmit <= 1'b0;
      tx_byte     <= 8'h00;
    end else begin
      done <= 1'b0;
      case (state)
        HS_IDLE: begin
          if (start) state <= HS_TX_LOAD;
        end
        HS_TX_LOAD: begin
          tx_byte     <= data;
          tx_transmit <= 1'b1;
          state       <= HS_TX_WAIT_HI;
        end
        HS_TX_WAIT_HI: begin
          if (tx_busy) begin
            tx_transmit <= 1'b0;
            state       <= HS_TX_WAIT_LO;
          end
        end
        HS_TX_WAIT_LO: begin
          if (!tx_busy) begin
            done  <= 1'b1;
            state <= HS_IDLE;
          end
        end
        default: state <= HS_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl
//   Byte-oriented command interpreter on top of a UART. Frames are a command
//   byte (bit7 write, bits[6:4] zero, bits[3:0] address) followed, for
//   writes, by four data bytes LSB-first. Writes update a 32-bit register and
//   reply ACK; reads reply with the register as four bytes LSB-first; illegal
//   commands reply NAK. Stalled or errored write frames are dropped silently
//   and counted.
// Ports
//   clk, rst_n               system clock, async active-low reset
//   rx_received/rx_byte      received byte strobe and value
//   rx_error                 UART framing-error strobe
//   tx_transmit/tx_byte      transmit request and byte
//   tx_busy                  UART is_transmitting
//   reg_flat                 register file, reg k at [32k+31:32k]
//   reg_wr/reg_wr_addr       one-cycle update strobe and register index
//   busy                     controller not idle
//   timeout_cnt              saturating count of aborted frames
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | waiting for a command byte
// ST_GET_DATA  | collecting 4 write-data bytes, inter-byte timer running
// ST_EXEC      | load reply (ACK or register contents) for transmission
// ST_TX        | reply bytes going out through uart_tx_hs, one per done
module uart_cmd_ctrl
  import uart_cmd_ctrl_pkg::*;
#(
  parameter int NUM_REGS    = 16,
  parameter int TIMEOUT_CYC = 120000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_received,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_error,
  output logic                  tx_transmit,
  output logic [7:0]            tx_byte,
  input  logic                  tx_busy,
  output logic [32*NUM_REGS-1:0] reg_flat,
  output logic                  reg_wr,
  output logic [3:0]            reg_wr_addr,
  output logic                  busy,
  output logic [7:0]            timeout_cnt
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC);

  ctrl_state_t      state;
  logic [31:0]      regs [NUM_REGS];
  logic [TMR_W-1:0] timer;
  logic             cmd_write;
  logic [3:0]       cmd_addr;
  logic [1:0]       byte_cnt;
  logic [23:0]      asm_word;
  logic [31:0]      tx_word;
  logic [2:0]       tx_left;
  logic             hs_start;
  logic             hs_done;

  assign busy = (state != ST_IDLE);

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign reg_flat[32*k +: 32] = regs[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
      timer       <= '0;
      cmd_write   <= 1'b0;
      cmd_addr    <= 4'd0;
      byte_cnt    <= 2'd0;
      asm_word    <= 24'd0;
      tx_word     <= 32'd0;
      tx_left     <= 3'd0;
      hs_start    <= 1'b0;
      reg_wr      <= 1'b0;
      reg_wr_addr <= 4'd0;
      timeout_cnt <= 8'd0;
    end else begin
      reg_wr   <= 1'b0;
      hs_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_received) begin
            cmd_write <= rx_byte[CMD_WR_BIT];
            cmd_addr  <= rx_byte[CMD_ADDR_HI:CMD_ADDR_LO];
            if (!cmd_is_legal(rx_byte, NUM_REGS)) begin
              tx_word  <= {24'd0, NAK};
              tx_left  <= 3'd1;
              hs_start <= 1'b1;
              state    <= ST_TX;
            end else if (rx_byte[CMD_WR_BIT]) begin
              byte_cnt <= 2'd0;
              timer    <= TMR_LOAD;
              state    <= ST_GET_DATA;
            end else begin
              // start is raised now so the handshake loads the reply
              // that EXEC prepares in the same cycle
              hs_start <= 1'b1;
              state    <= ST_EXEC;
            end
          end
        end
        ST_GET_DATA: begin
          if (rx_error) begin
            timer       <= '0;
            timeout_cnt <= sat_inc8(timeout_cnt);
            state       <= ST_IDLE;
          end else if (rx_received) begin
            timer    <= TMR_LOAD;
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: asm_word[7:0]   <= rx_byte;
              2'd1: asm_word[15:8]  <= rx_byte;
              2'd2: asm_word[23:16] <= rx_byte;
              default: begin
                // Register and reg_wr change together on EXEC entry, so a
                // consumer sampling on reg_wr already sees the new word.
                regs[cmd_addr] <= {rx_byte, asm_word};
                reg_wr         <= 1'b1;
                reg_wr_addr    <= cmd_addr;
                timer          <= '0;
                hs_start       <= 1'b1;
                state          <= ST_EXEC;
              end
            endcase
          end else if (timer == '0) begin
            timeout_cnt <= sat_inc8(timeout_cnt);
            state       <= ST_IDLE;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_EXEC: begin
          if (cmd_write) begin
            tx_word <= {24'd0, ACK};
            tx_left <= 3'd1;
          end else begin
            tx_word <= regs[cmd_addr];
            tx_left <= 3'd4;
          end
          state <= ST_TX;
        end
        ST_TX: begin
          if (hs_done) begin
            if (tx_left == 3'd1) begin
              tx_left <= 3'd0;
              state   <= ST_IDLE;
            end else begin
              tx_word  <= {8'd0, tx_word[31:8]};
              tx_left  <= tx_left - 3'd1;
              hs_start <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_tx_hs u_tx_hs (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (hs_start),
    .data        (tx_word[7:0]),
    .done        (hs_done),
    .tx_transmit (tx_transmit),
    .tx_byte     (tx_byte),
    .tx_busy     (tx_busy)
  );

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 Parameter NUM_REGS, default 16: number of 32-bit pulse-configuration registers (max 16).
REQ-002 Parameter TIMEOUT_CYC, default 120000: inter-byte timeout in clk cycles (10 ms at 12 MHz).
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rx_received  input  1  one-cycle strobe from UART receiver: rx_byte valid.
REQ-006 rx_byte  input  8  received byte.
REQ-007 rx_error  input  1  one-cycle UART framing-error strobe.
REQ-008 tx_transmit  output  1  request to UART transmitter.
REQ-009 tx_byte  output  8  byte to transmit; stable while tx_transmit=1.
REQ-010 tx_busy  input  1  UART is_transmitting.
REQ-011 reg_flat  output  32*NUM_REGS  register file, reg k at bits [32k+31:32k].
REQ-012 reg_wr  output  1  one-cycle strobe when a register is updated.
REQ-013 reg_wr_addr  output  4  index of the register updated by reg_wr.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 timeout_cnt  output  8  saturating count of aborted frames (timeout or rx_error).

Function
REQ-016 Frame format: command byte, then 4 data bytes LSB-first for writes; cmd[7]=1 write, cmd[7]=0 read, cmd[3:0]=addr, cmd[6:4] must be 000.
REQ-017 FSM states: IDLE, GET_DATA, EXEC, TX_LOAD, TX_WAIT_HI, TX_WAIT_LO.
REQ-018 IDLE + rx_received: latch command; illegal (cmd[6:4]!=0 or addr>=NUM_REGS) -> queue NAK 0x15 -> TX_LOAD; valid write -> GET_DATA with byte count 0; valid read -> EXEC.
REQ-019 GET_DATA: each rx_received shifts the byte into a 32-bit assembly register at byte position count; after the 4th byte -> EXEC.
REQ-020 Inter-byte timer reloads to TIMEOUT_CYC on every accepted byte in GET_DATA; on reaching 0 -> IDLE, partial data discarded, timeout_cnt+1 (saturates at 255), no reply.
REQ-021 rx_error in GET_DATA -> IDLE, timeout_cnt+1, no reply; rx_error in IDLE is ignored.
REQ-022 EXEC (1 cycle): write -> reg[addr] <= assembled word, reg_wr=1, reg_wr_addr=addr, queue ACK 0x06 (1 byte); read -> queue reg[addr] as 4 bytes LSB-first.
REQ-023 TX_LOAD: drive tx_byte, assert tx_transmit -> TX_WAIT_HI.
REQ-024 TX_WAIT_HI: hold tx_transmit=1 until tx_busy=1, then deassert tx_transmit -> TX_WAIT_LO.
REQ-025 TX_WAIT_LO: wait for tx_busy=0; more bytes queued -> TX_LOAD, else -> IDLE.
REQ-026 tx_transmit SHALL be 0 for at least one cycle between bytes so the transmitter's recover state releases.
REQ-027 rx_received during EXEC/TX_* states is dropped, with no state change.
REQ-028 Read of a register in the same frame as its prior write returns the new value (write completes in EXEC before any later read).
REQ-029 Latency: reg_wr asserts 1 cycle after the 4th data byte's rx_received; tx_transmit asserts 2 cycles after EXEC is entered.

Reset
REQ-030 On rst_n=0, immediately: state IDLE, all registers 0, tx_transmit 0, tx_byte 0x00, reg_wr 0, reg_wr_addr 0, busy 0, timeout_cnt 0, timer 0.
REQ-031 Reset mid-transmission drops tx_transmit at once; the byte in flight in the UART is not tracked.

Structure
REQ-032 Shared header uart_cmd_defs.vh holds the state encodings, ACK (0x06), NAK (0x15), and command bit-field positions.
REQ-033 The TX_LOAD/WAIT_HI/WAIT_LO handshake SHALL be a sub-module uart_tx_hs (inputs start and byte, output done) instantiated once.

Verification
REQ-034 Write 0x83,0x78,0x56,0x34,0x12 -> reg3=0x12345678, one reg_wr pulse with addr 3, tx sends 0x06.
REQ-035 Read 0x03 after REQ-034 -> tx sends 0x78,0x56,0x34,0x12 in order, each with a transmit low gap.
REQ-036 Command 0x93 -> NAK 0x15, no reg_wr, FSM returns to IDLE.
REQ-037 0x85,0x11 then silence > TIMEOUT_CYC -> IDLE, reg5 unchanged, timeout_cnt=1, no tx.
REQ-038 rx_error after the 2nd data byte of a write -> abort, timeout_cnt+1; next frame 0x81 plus 4 bytes is accepted correctly.
REQ-039 rst_n low during TX_WAIT_HI -> tx_transmit=0 that cycle, all regs 0, busy 0.
